// File: rtl/riscv_base_pkg.sv
// Shared RV32I(M) base definitions: opcodes, funct fields, formats, causes
// and the decoded instruction bundle handed from decode to execute.
package riscv_base_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010
  } store_funct3_e;

  typedef enum logic [2:0] {
    F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100,
    F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111
  } branch_funct3_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011,
    F3_XOR = 3'b100, F3_SRL_SRA = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111
  } alu_funct3_e;

  typedef enum logic [2:0] {
    F3_PRIV = 3'b000, F3_CSRRW = 3'b001, F3_CSRRS = 3'b010, F3_CSRRC = 3'b011,
    F3_SYS_RSVD = 3'b100, F3_CSRRWI = 3'b101, F3_CSRRSI = 3'b110, F3_CSRRCI = 3'b111
  } system_funct3_e;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0, TYPE_I = 3'd1, TYPE_S = 3'd2, TYPE_B = 3'd3, TYPE_U = 3'd4, TYPE_J = 3'd5
  } inst_type_e;

  typedef enum logic [31:0] {
    CAUSE_NONE                = 32'd0,
    CAUSE_ILLEGAL_INSTRUCTION = 32'd2
  } exception_cause_e;

  localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;
  localparam logic [6:0] FUNCT7_M_EXT = 7'b0000001;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_WFI    = 32'h1050_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [31:0]      pc;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    inst_type_e       itype;
    logic             rd_we;
    logic             is_mext;
    logic             illegal;
    exception_cause_e exc_cause;
  } decoded_inst_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the
// immediate of an instruction word according to its format.
module riscv_imm_gen
  import riscv_base_pkg::*;
(
  input  logic [31:0] inst_i,
  input  inst_type_e  type_i,
  output logic [31:0] imm_o
);

  // Opcode bits never contribute to an immediate.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^inst_i[6:0];

  always_comb begin
    case (type_i)
      TYPE_I:  imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      TYPE_S:  imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      TYPE_B:  imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      TYPE_U:  imm_o = {inst_i[31:12], 12'd0};
      TYPE_J:  imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I(M) decode stage with a two-entry (main + skid) output buffer.
// Define RISCV_M_EXT_EN to decode the M extension; otherwise it is illegal.
module riscv_decode_stage
  import riscv_base_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [6:0]      dec_opcode_o,
  output logic [4:0]      dec_rd_o,
  output logic [4:0]      dec_rs1_o,
  output logic [4:0]      dec_rs2_o,
  output logic [2:0]      dec_funct3_o,
  output logic [6:0]      dec_funct7_o,
  output logic [XLEN-1:0] dec_imm_o,
  output logic [2:0]      dec_type_o,
  output logic            dec_rd_we_o,
  output logic            dec_is_mext_o,
  output logic            dec_illegal_o,
  output logic [31:0]     dec_exc_cause_o
);

  logic [6:0]    opcode_s;
  logic [2:0]    funct3_s;
  logic [6:0]    funct7_s;
  logic [4:0]    rd_s;
  inst_type_e    type_s;
  logic          illegal_s;
  logic          is_mext_s;
  logic [31:0]   imm_s;
  decoded_inst_t decoded_s;
  decoded_inst_t idle_s;

  decoded_inst_t main_d, main_q, skid_d, skid_q;
  logic          main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;
  logic          accept_s, drain_s;

  assign opcode_s = in_inst_i[6:0];
  assign rd_s     = in_inst_i[11:7];
  assign funct3_s = in_inst_i[14:12];
  assign funct7_s = in_inst_i[31:25];

  // Format selection and legality check for the incoming word.
  always_comb begin
    type_s    = TYPE_R;
    illegal_s = 1'b0;
    is_mext_s = 1'b0;
    case (opcode_s)
      OPC_LOAD: begin
        type_s = TYPE_I;
        case (funct3_s)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal_s = 1'b0;
          default:                             illegal_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        type_s    = TYPE_S;
        illegal_s = (funct3_s > F3_SW);
      end
      OPC_BRANCH: begin
        type_s = TYPE_B;
        case (funct3_s)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: illegal_s = 1'b0;
          default:                                         illegal_s = 1'b1;
        endcase
      end
      OPC_JALR: begin
        type_s    = TYPE_I;
        illegal_s = (funct3_s != 3'd0);
      end
      OPC_JAL:                type_s = TYPE_J;
      OPC_LUI, OPC_AUIPC:     type_s = TYPE_U;
      OPC_MISC_MEM:           type_s = TYPE_I;
      OPC_OP_IMM: begin
        type_s = TYPE_I;
        if (funct3_s == F3_SLL) begin
          illegal_s = (funct7_s != FUNCT7_BASE);
        end else if (funct3_s == F3_SRL_SRA) begin
          illegal_s = (funct7_s != FUNCT7_BASE) && (funct7_s != FUNCT7_ALT);
        end else begin
          illegal_s = 1'b0;
        end
      end
      OPC_OP: begin
        type_s = TYPE_R;
        case (funct7_s)
          FUNCT7_BASE:  illegal_s = 1'b0;
          FUNCT7_ALT:   illegal_s = (funct3_s != F3_ADD_SUB) && (funct3_s != F3_SRL_SRA);
`ifdef RISCV_M_EXT_EN
          FUNCT7_M_EXT: is_mext_s = 1'b1;
`else
          FUNCT7_M_EXT: illegal_s = 1'b1;
`endif
          default:      illegal_s = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        type_s = TYPE_I;
        if (funct3_s == F3_SYS_RSVD) begin
          illegal_s = 1'b1;
        end else if (funct3_s == F3_PRIV) begin
          illegal_s = !((in_inst_i == INST_ECALL) || (in_inst_i == INST_EBREAK) ||
                        (in_inst_i == INST_WFI)   || (in_inst_i == INST_MRET));
        end else begin
          illegal_s = 1'b0;
        end
      end
      default: illegal_s = 1'b1;
    endcase
    if (in_inst_i[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = illegal_s;
    end
  end

  riscv_imm_gen u_imm_gen (
    .inst_i (in_inst_i),
    .type_i (type_s),
    .imm_o  (imm_s)
  );

  // Assemble the decoded bundle and the idle bundle shown when nothing is held.
  always_comb begin
    idle_s    = '0;
    idle_s.pc = RESET_PC_TAG;

    decoded_s.pc        = in_pc_i;
    decoded_s.opcode    = opcode_s;
    decoded_s.rd        = rd_s;
    decoded_s.rs1       = in_inst_i[19:15];
    decoded_s.rs2       = in_inst_i[24:20];
    decoded_s.funct3    = funct3_s;
    decoded_s.funct7    = funct7_s;
    decoded_s.imm       = imm_s;
    decoded_s.itype     = type_s;
    decoded_s.illegal   = illegal_s;
    decoded_s.is_mext   = is_mext_s && !illegal_s;
    decoded_s.rd_we     = !illegal_s && (rd_s != 5'd0) && (opcode_s != OPC_BRANCH) &&
                          (opcode_s != OPC_STORE) && (opcode_s != OPC_MISC_MEM);
    decoded_s.exc_cause = illegal_s ? CAUSE_ILLEGAL_INSTRUCTION : CAUSE_NONE;
  end

  assign in_ready_o = !skid_valid_q && !rst_i;
  assign accept_s   = in_valid_i && in_ready_o;
  assign drain_s    = main_valid_q && dec_ready_i;

  // Main/skid next state; an emptied main register reverts to the idle bundle.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_d       = idle_s;
      main_valid_d = 1'b0;
      skid_d       = idle_s;
      skid_valid_d = 1'b0;
    end else if (drain_s) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_d       = idle_s;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        main_d       = decoded_s;
        main_valid_d = 1'b1;
      end else begin
        main_d       = idle_s;
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      if (main_valid_q) begin
        skid_d       = decoded_s;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = decoded_s;
        main_valid_d = 1'b1;
      end
    end else begin
      main_d = main_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q       <= idle_s;
      main_valid_q <= 1'b0;
      skid_q       <= idle_s;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign dec_valid_o     = main_valid_q;
  assign dec_pc_o        = main_q.pc;
  assign dec_opcode_o    = main_q.opcode;
  assign dec_rd_o        = main_q.rd;
  assign dec_rs1_o       = main_q.rs1;
  assign dec_rs2_o       = main_q.rs2;
  assign dec_funct3_o    = main_q.funct3;
  assign dec_funct7_o    = main_q.funct7;
  assign dec_imm_o       = main_q.imm;
  assign dec_type_o      = main_q.itype;
  assign dec_rd_we_o     = main_q.rd_we;
  assign dec_is_mext_o   = main_q.is_mext;
  assign dec_illegal_o   = main_q.illegal;
  assign dec_exc_cause_o = main_q.exc_cause;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: expected bundles are queued on
// accept and compared when execute takes them.
module tb_riscv_decode_stage;
  import riscv_base_pkg::*;

  localparam logic [31:0] TAG = 32'h0000_BEEC;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_inst_i = 32'd0;
  logic [31:0] in_pc_i = 32'd0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] dec_pc_o;
  logic [6:0]  dec_opcode_o;
  logic [4:0]  dec_rd_o, dec_rs1_o, dec_rs2_o;
  logic [2:0]  dec_funct3_o;
  logic [6:0]  dec_funct7_o;
  logic [31:0] dec_imm_o;
  logic [2:0]  dec_type_o;
  logic        dec_rd_we_o, dec_is_mext_o, dec_illegal_o;
  logic [31:0] dec_exc_cause_o;

  riscv_decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o), .dec_opcode_o(dec_opcode_o),
    .dec_rd_o(dec_rd_o), .dec_rs1_o(dec_rs1_o), .dec_rs2_o(dec_rs2_o),
    .dec_funct3_o(dec_funct3_o), .dec_funct7_o(dec_funct7_o),
    .dec_imm_o(dec_imm_o), .dec_type_o(dec_type_o),
    .dec_rd_we_o(dec_rd_we_o), .dec_is_mext_o(dec_is_mext_o),
    .dec_illegal_o(dec_illegal_o), .dec_exc_cause_o(dec_exc_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] word;
    logic [31:0] imm;
    inst_type_e  itype;
    logic        chk_imm;
    logic        we;
    logic        mext;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  vec_t        cur_v;
  int          checks = 0;
  int          errors = 0;
  logic        hold_chk = 1'b0;
  logic [31:0] held_pc = 32'd0;
  logic [31:0] pc_ctr = 32'h0000_0100;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] w, input logic [31:0] imm, input inst_type_e t,
                         input logic ci, input logic we, input logic mx, input logic il);
    vec_t v;
    v.word = w; v.imm = imm; v.itype = t; v.chk_imm = ci;
    v.we = we; v.mext = mx; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("spurious_out", 32'(dec_valid_o), 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq("pc", dec_pc_o, e.pc);
    check_eq("opcode", 32'(dec_opcode_o), 32'(e.v.word[6:0]));
    check_eq("rd", 32'(dec_rd_o), 32'(e.v.word[11:7]));
    check_eq("funct3", 32'(dec_funct3_o), 32'(e.v.word[14:12]));
    check_eq("rs1", 32'(dec_rs1_o), 32'(e.v.word[19:15]));
    check_eq("rs2", 32'(dec_rs2_o), 32'(e.v.word[24:20]));
    check_eq("funct7", 32'(dec_funct7_o), 32'(e.v.word[31:25]));
    if (e.v.chk_imm) begin
      check_eq("imm", dec_imm_o, e.v.imm);
      check_eq("type", 32'(dec_type_o), 32'(e.v.itype));
    end
    check_eq("rd_we", 32'(dec_rd_we_o), 32'(e.v.we));
    check_eq("is_mext", 32'(dec_is_mext_o), 32'(e.v.mext));
    check_eq("illegal", 32'(dec_illegal_o), 32'(e.v.ill));
    check_eq("exc_cause", dec_exc_cause_o, e.v.ill ? 32'd2 : 32'd0);
  endtask

  // Called at a negedge with inputs already set; evaluates the coming edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (hold_chk) check_eq("hold_pc", dec_pc_o, held_pc);
    hold_chk = 1'b0;
    if (dec_valid_o && dec_ready_i) begin
      compare_out();
    end else if (dec_valid_o && !flush_i && !rst_i) begin
      hold_chk = 1'b1;
      held_pc  = dec_pc_o;
    end
    if (flush_i || rst_i) begin
      sb.delete();
    end else if (in_valid_i && in_ready_o) begin
      e.v = cur_v; e.pc = in_pc_i;
      sb.push_back(e);
    end
    @(negedge clk_i);
  endtask

  task automatic send(input int idx, input int ready_pct);
    logic acc;
    acc = 1'b0;
    cur_v = vecs[idx];
    in_valid_i = 1'b1; in_inst_i = cur_v.word; in_pc_i = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    for (int t = 0; t < 50; t++) begin
      dec_ready_i = ($urandom_range(99) < ready_pct);
      acc = in_ready_o;
      cycle();
      if (acc) break;
    end
    check_eq("accept_timeout", 32'(acc), 32'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    in_valid_i = 1'b0; dec_ready_i = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    check_eq("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add_vec(32'hFFF0_0093, 32'hFFFF_FFFF, TYPE_I, 1'b1, 1'b1, 1'b0, 1'b0); // addi x1,x0,-1
    add_vec(32'hFE00_0EE3, 32'hFFFF_FFFC, TYPE_B, 1'b1, 1'b0, 1'b0, 1'b0); // beq -4
`ifdef RISCV_M_EXT_EN
    add_vec(32'h0220_81B3, 32'h0000_0000, TYPE_R, 1'b1, 1'b1, 1'b1, 1'b0); // mul
`else
    add_vec(32'h0220_81B3, 32'h0000_0000, TYPE_R, 1'b1, 1'b0, 1'b0, 1'b1); // mul
`endif
    add_vec(32'h0000_0000, 32'h0000_0000, TYPE_R, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(32'h1234_52B7, 32'h1234_5000, TYPE_U, 1'b1, 1'b1, 1'b0, 1'b0); // lui x5
    add_vec(32'h0020_A423, 32'h0000_0008, TYPE_S, 1'b1, 1'b0, 1'b0, 1'b0); // sw x2,8(x1)
    add_vec(32'h0100_00EF, 32'h0000_0010, TYPE_J, 1'b1, 1'b1, 1'b0, 1'b0); // jal x1,16
    add_vec(32'h0000_0073, 32'h0000_0000, TYPE_I, 1'b1, 1'b0, 1'b0, 1'b0); // ecall
    add_vec(32'h3020_0073, 32'h0000_0302, TYPE_I, 1'b1, 1'b0, 1'b0, 1'b0); // mret
    add_vec(32'h0020_0073, 32'h0000_0002, TYPE_I, 1'b1, 1'b0, 1'b0, 1'b1); // bad priv
    add_vec(32'h0000_10E7, 32'h0000_0000, TYPE_I, 1'b1, 1'b0, 1'b0, 1'b1); // jalr f3=1
    add_vec(32'h0000_3083, 32'h0000_0000, TYPE_I, 1'b1, 1'b0, 1'b0, 1'b1); // load f3=3
    add_vec(32'h4031_00B3, 32'h0000_0000, TYPE_R, 1'b1, 1'b1, 1'b0, 1'b0); // sub
    add_vec(32'h4031_10B3, 32'h0000_0000, TYPE_R, 1'b1, 1'b0, 1'b0, 1'b1); // alt sll
    add_vec(32'h4031_5093, 32'h0000_0403, TYPE_I, 1'b1, 1'b1, 1'b0, 1'b0); // srai
    add_vec(32'h4031_1093, 32'h0000_0403, TYPE_I, 1'b1, 1'b0, 1'b0, 1'b1); // bad slli
    add_vec(32'h0010_0013, 32'h0000_0001, TYPE_I, 1'b1, 1'b0, 1'b0, 1'b0); // addi x0
    add_vec(32'hFFF1_0083, 32'hFFFF_FFFF, TYPE_I, 1'b1, 1'b1, 1'b0, 1'b0); // lb
    add_vec(32'h0000_2063, 32'h0000_0000, TYPE_B, 1'b1, 1'b0, 1'b0, 1'b1); // branch f3=2
    add_vec(32'h0000_0092, 32'h0000_0000, TYPE_R, 1'b0, 1'b0, 1'b0, 1'b1); // low bits 10

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    check_eq("rst_in_ready", 32'(in_ready_o), 32'd0);
    check_eq("rst_valid", 32'(dec_valid_o), 32'd0);
    check_eq("rst_pc", dec_pc_o, TAG);
    check_eq("rst_imm", dec_imm_o, 32'd0);
    check_eq("rst_flags", {29'd0, dec_rd_we_o, dec_illegal_o, dec_is_mext_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Back-to-back stream, then randomly backpressured stream
    for (int i = 0; i < vecs.size(); i++) send(i, 100);
    drain();
    for (int i = 0; i < vecs.size(); i++) send(i, 50);
    drain();
    check_eq("idle_pc", dec_pc_o, TAG);

    // Explicit backpressure: two held, third refused, then released in order
    send(0, 0);
    send(1, 0);
    check_eq("bp_ready_low", 32'(in_ready_o), 32'd0);
    cur_v = vecs[2]; in_valid_i = 1'b1; in_inst_i = cur_v.word; in_pc_i = pc_ctr;
    repeat (3) cycle();
    check_eq("bp_still_low", 32'(in_ready_o), 32'd0);
    send(2, 100);
    drain();

    // Flush while an accept happens on top of one held entry
    send(0, 0);
    cur_v = vecs[3]; in_valid_i = 1'b1; in_inst_i = cur_v.word; in_pc_i = 32'hBAD0_0000;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_eq("flush1_valid", 32'(dec_valid_o), 32'd0);
    check_eq("flush1_ready", 32'(in_ready_o), 32'd1);

    // Flush with both entries held and an instruction offered
    send(4, 0);
    send(5, 0);
    cur_v = vecs[6]; in_valid_i = 1'b1; in_inst_i = cur_v.word; in_pc_i = 32'hBAD0_0004;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_eq("flush2_valid", 32'(dec_valid_o), 32'd0);
    check_eq("flush2_ready", 32'(in_ready_o), 32'd1);
    check_eq("flush2_pc", dec_pc_o, TAG);
    send(7, 100);
    drain();

    // Reset mid-stream discards held entries
    send(8, 0);
    send(12, 0);
    rst_i = 1'b1;
    cycle();
    #1;
    check_eq("mid_rst_ready", 32'(in_ready_o), 32'd0);
    check_eq("mid_rst_valid", 32'(dec_valid_o), 32'd0);
    check_eq("mid_rst_pc", dec_pc_o, TAG);
    @(negedge clk_i);
    rst_i = 1'b0;
    send(14, 100);
    drain();
    check_eq("end_valid", 32'(dec_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
